// File: rtl/alu_op_sequencer_if.sv
// Handshake and ALU-drive bundle for alu_op_sequencer.
// slave is the sequencer's view; master is the view of whatever drives it.
interface alu_op_sequencer_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_a;
  logic [3:0] cmd_b;
  logic [1:0] cmd_sel;

  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [1:0] alu_sel;
  logic [3:0] alu_y;
  logic       alu_z;

  logic       res_valid;
  logic       res_ready;
  logic [3:0] res_y;
  logic       res_z;
  logic [1:0] res_sel;

  logic       busy;
  logic [7:0] op_count;

  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_sel, alu_y, alu_z, res_ready,
    output cmd_ready, alu_a, alu_b, alu_sel, res_valid, res_y, res_z, res_sel,
           busy, op_count
  );

  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_sel, alu_y, alu_z, res_ready,
    input  cmd_ready, alu_a, alu_b, alu_sel, res_valid, res_y, res_z, res_sel,
           busy, op_count
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Queues ALU commands, drives each onto a combinational ALU for SETTLE cycles,
// then captures and presents the result through a valid/ready handshake.
module alu_op_sequencer #(
  parameter int FIFO_DEPTH = 4,
  parameter int SETTLE     = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  alu_op_sequencer_if.slave  bus
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(SETTLE + 1);
  localparam int ENT_W = 10;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } state_t;

  state_t             state;
  logic [ENT_W-1:0]   mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W:0]     count;
  logic [CNT_W-1:0]   settle_cnt;
  logic [ENT_W-1:0]   head;
  logic               full;
  logic               empty;
  logic               push;
  logic               pop;
  logic               res_done;

  assign full     = (count == (PTR_W+1)'(FIFO_DEPTH));
  assign empty    = (count == '0);
  // Ready is forced low while reset is held so nothing is accepted into a FIFO being cleared.
  assign bus.cmd_ready = rst_n && !full;
  assign push     = bus.cmd_valid && bus.cmd_ready;
  assign head     = mem[rd_ptr];
  assign res_done = (state == DONE) && bus.res_valid && bus.res_ready;
  assign pop      = !empty && ((state == IDLE) || res_done);
  assign bus.busy = (state != IDLE) || !empty;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {bus.cmd_a, bus.cmd_b, bus.cmd_sel};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      settle_cnt    <= '0;
      bus.alu_a     <= '0;
      bus.alu_b     <= '0;
      bus.alu_sel   <= '0;
      bus.res_y     <= '0;
      bus.res_z     <= 1'b0;
      bus.res_sel   <= '0;
      bus.res_valid <= 1'b0;
      bus.op_count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      case (state)
        IDLE: begin
          if (!empty) begin
            bus.alu_a   <= head[9:6];
            bus.alu_b   <= head[5:2];
            bus.alu_sel <= head[1:0];
            settle_cnt  <= CNT_W'(SETTLE);
            state       <= WAIT;
          end
        end

        // Operands have been stable on the ALU for SETTLE cycles when the counter leaves 1.
        WAIT: begin
          settle_cnt <= settle_cnt - 1'b1;
          if (settle_cnt == CNT_W'(1)) begin
            bus.res_y     <= bus.alu_y;
            bus.res_z     <= bus.alu_z;
            bus.res_sel   <= bus.alu_sel;
            bus.res_valid <= 1'b1;
            state         <= DONE;
          end
        end

        DONE: begin
          if (res_done) begin
            bus.res_valid <= 1'b0;
            bus.op_count  <= bus.op_count + 8'd1;
            if (!empty) begin
              bus.alu_a   <= head[9:6];
              bus.alu_b   <= head[5:2];
              bus.alu_sel <= head[1:0];
              settle_cnt  <= CNT_W'(SETTLE);
              state       <= WAIT;
            end else begin
              state       <= IDLE;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer with an adder ALU model on the ALU port.
module tb_alu_op_sequencer;

  localparam int FIFO_DEPTH = 4;
  localparam int SETTLE     = 1;

  typedef struct packed {
    logic [3:0] y;
    logic       z;
    logic [1:0] sel;
  } res_t;

  logic clk;
  logic rst_n;
  alu_op_sequencer_if bus ();

  alu_op_sequencer #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .SETTLE     (SETTLE)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // Downstream ALU: 4-bit add with carry out as the flag.
  assign {bus.alu_z, bus.alu_y} = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fails  = 0;
  res_t exp_q[$];
  int   exp_cnt  = 0;
  logic hold_prev = 1'b0;
  logic [17:0] snap_prev;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, req, $time);
    end
  endtask

  function automatic res_t model(input logic [3:0] a, input logic [3:0] b, input logic [1:0] sel);
    logic [4:0] sum;
    res_t r;
    sum   = {1'b0, a} + {1'b0, b};
    r.y   = sum[3:0];
    r.z   = sum[4];
    r.sel = sel;
    return r;
  endfunction

  // Monitor: everything sampled on the falling edge, acting on what the next rising edge commits.
  always @(negedge clk) begin
    logic [17:0] snap;
    res_t r;
    snap = {bus.alu_a, bus.alu_b, bus.alu_sel, bus.res_y, bus.res_z, bus.res_sel, bus.res_valid};
    if (!rst_n) begin
      exp_q.delete();
      exp_cnt   = 0;
      hold_prev = 1'b0;
    end else begin
      chk("op_count", bus.op_count, exp_cnt);
      if (hold_prev) chk("hold_stable", snap, snap_prev);
      if (bus.res_valid) begin
        chk("res_has_cmd", exp_q.size() != 0, 1);
        if (bus.res_ready && exp_q.size() != 0) begin
          r = exp_q.pop_front();
          chk("res_order", {bus.res_y, bus.res_z, bus.res_sel}, r);
          exp_cnt = (exp_cnt + 1) % 256;
        end
      end
      if (bus.cmd_valid && bus.cmd_ready) begin
        exp_q.push_back(model(bus.cmd_a, bus.cmd_b, bus.cmd_sel));
      end
      hold_prev = bus.res_valid && !bus.res_ready;
      snap_prev = snap;
    end
  end

  // Offer one command; returns one rising edge after it is accepted.
  task automatic send(input logic [3:0] a, input logic [3:0] b, input logic [1:0] sel,
                      output int waits);
    waits = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_a     = a;
    bus.cmd_b     = b;
    bus.cmd_sel   = sel;
    @(negedge clk);
    while (!bus.cmd_ready && waits < 2000) begin
      @(negedge clk);
      waits++;
    end
    if (waits >= 2000) chk("send_timeout", waits < 2000, 1);
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int t;
    t = 0;
    @(negedge clk);
    while ((bus.busy || bus.res_valid) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_timeout"}, t < 3000, 1);
    @(negedge clk);
    chk({tag, "_drained"}, exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int w;
    int n;
    logic [3:0] ta [4];
    logic [3:0] tb [4];

    rst_n         = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_a     = '0;
    bus.cmd_b     = '0;
    bus.cmd_sel   = '0;
    bus.res_ready = 1'b0;

    // Reset behaviour and state after release.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_ready_low", bus.cmd_ready, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_cmd_ready_high", bus.cmd_ready, 1);
    chk("rst_res_valid", bus.res_valid, 0);
    chk("rst_op_count", bus.op_count, 0);
    chk("rst_alu", {bus.alu_a, bus.alu_b, bus.alu_sel}, 0);
    chk("rst_busy", bus.busy, 0);
    @(posedge clk);
    #1;

    // Single op F+1 and its latency.
    bus.res_ready = 1'b1;
    send(4'hF, 4'h1, 2'b00, w);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.res_valid && n < 20);
    chk("single_latency", n - 1, 1 + SETTLE);
    chk("single_res", {bus.res_y, bus.res_z, bus.res_sel}, {4'h0, 1'b1, 2'b00});
    @(negedge clk);
    chk("single_op_count", bus.op_count, 1);
    chk("single_busy", bus.busy, 0);
    @(posedge clk);
    #1;

    // Back-to-back queue of four with the sink always ready.
    ta = '{4'h1, 4'h4, 4'hA, 4'h5};
    tb = '{4'h1, 4'h3, 4'h2, 4'h5};
    for (int i = 0; i < 4; i++) send(ta[i], tb[i], 2'(i), w);
    n = 0;
    @(negedge clk);
    while (bus.busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_busy_after_last", exp_q.size(), 0);
    chk("b2b_op_count", bus.op_count, 5);
    @(posedge clk);
    #1;

    // Backpressure: five commands fill the in-flight slot and all FIFO entries.
    bus.res_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(4'(i + 3), 4'(2 * i + 7), 2'(i), w);
    repeat (4) begin
      @(negedge clk);
      chk("bp_cmd_ready", bus.cmd_ready, 0);
      chk("bp_res_valid", bus.res_valid, 1);
    end
    @(posedge clk);
    #1;
    // Full FIFO with a completing result: the offered command waits one cycle.
    bus.res_ready = 1'b1;
    send(4'h9, 4'h9, 2'b11, w);
    chk("full_pop_wait", w, 1);
    wait_idle("bp");

    // Reset while holding a result with two commands queued.
    bus.res_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(4'(i + 1), 4'hE, 2'b01, w);
    n = 0;
    @(negedge clk);
    while (!bus.res_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("mid_reach_done", bus.res_valid, 1);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    bus.res_ready = 1'b1;
    @(negedge clk);
    chk("mid_res", {bus.res_valid, bus.res_y, bus.res_z, bus.res_sel}, 0);
    chk("mid_alu", {bus.alu_a, bus.alu_b, bus.alu_sel}, 0);
    chk("mid_op_count", bus.op_count, 0);
    chk("mid_cmd_ready", bus.cmd_ready, 1);
    chk("mid_busy", bus.busy, 0);
    n = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.res_valid) n++;
    end
    chk("mid_no_res", n, 0);
    @(posedge clk);
    #1;

    // 256 random operations wrap op_count back to zero.
    for (int i = 0; i < 256; i++) begin
      send(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), w);
      if (i == 127) chk("wrap_midway_ready", bus.res_ready, 1);
    end
    wait_idle("wrap");
    @(negedge clk);
    chk("wrap_op_count", bus.op_count, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
